mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  Sequences every memory transaction of the multicycle CPU on behalf of the main control unit.
//  Drives the memory-address mux select (IorD_Sel), Mem_WR, and the IR/MDR load strobes.
//  Waits out the memory read latency and performs byte/halfword stores as read-modify-write.
//  The control FSM issues one request, then waits for done.
// PARAMETERS
//  MEM_LATENCY  2  cycles from address stable to mem_rdata valid; legal range 1..7
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high
//  req_valid    in   1   request strobe; sampled only while req_ready=1
//  req_ready    out  1   1 only in IDLE
//  req_kind     in   2   00 fetch, 01 load, 10 store, 11 exception-vector read
//  req_size     in   2   00 word, 01 half, 10 byte, 11 illegal
//  req_src      in   2   address source for load/store: 00 alu_out, 01 reg_A, 10 reg_B, 11 illegal
//  addr_lo      in   2   low two bits of the address being selected, valid with req_valid
//  store_data   in   32  reg_B value to store, valid with req_valid
//  mem_rdata    in   32  memory read data
//  IorD_Sel     out  3   000 PC, 001 alu_out, 010 reg_A, 011 reg_B, 100 exception-vector mux
//  Mem_WR       out  1   memory write enable, high exactly one cycle per store
//  mem_wdata    out  32  write data to memory
//  IR_Load      out  1   one-cycle strobe: capture mem_rdata into IR
//  MDR_Load     out  1   one-cycle strobe: capture mem_rdata into MDR
//  done         out  1   one-cycle completion pulse, including error completions
//  err          out  2   valid only with done: 00 ok, 01 misaligned, 10 illegal request
// BEHAVIOUR
//  Reset values (asynchronous, immediate):
//   - state=IDLE; IorD_Sel=000; Mem_WR, IR_Load, MDR_Load, done=0; err=00; mem_wdata=0; req_ready=1.
//   - Reset mid-transaction aborts it with no write issued and no done pulse.
//  States are IDLE, WAIT, CAPT, WRITE and ERR. All outputs are registered or decoded from the state.
//  IDLE (accept at cycle T, req_valid=1):
//   - Latch kind, size, src, addr_lo and store_data.
//   - IorD_Sel is registered from T+1 and held constant until the request leaves CAPT, WRITE or ERR.
//   - Fetch forces sel 000. Exception read forces sel 100. Load/store map req_src 00/01/10 to sel 001/010/011.
//  Check priority at accept: illegal, then misaligned, then normal.
//   - Illegal: req_size=11, or req_src=11 on a load/store, or fetch with size!=word. Go to ERR with err=10.
//   - Misaligned: word with addr_lo!=00, or half with addr_lo[0]=1. Go to ERR with err=01.
//   - ERR lasts one cycle at T+1: done=1, no memory access, then IDLE. IorD_Sel returns to 000.
//  Store word: WRITE at T+1 with Mem_WR=1 and mem_wdata=latched store_data; done=1 in the same cycle.
//  Fetch, load and exception read:
//   - WAIT occupies T+1..T+MEM_LATENCY, using a 3-bit down-counter.
//   - CAPT at T+MEM_LATENCY+1: IR_Load=1 for a fetch, MDR_Load=1 otherwise; done=1.
//  Store half/byte (read-modify-write, little-endian lanes):
//   - WAIT as above.
//   - On the last WAIT edge, the merge register takes mem_rdata with one lane replaced by store_data's low bits.
//   - Byte: lane addr_lo, bits [8*addr_lo+7 : 8*addr_lo].
//   - Half: lane addr_lo[1], bits [16*addr_lo[1]+15 : 16*addr_lo[1]].
//   - WRITE at T+MEM_LATENCY+1: Mem_WR=1, mem_wdata=merge register, done=1.
//  After CAPT, WRITE or ERR: return to IDLE; the next accept is possible that same next cycle.
//  Back-to-back requests therefore get one idle-state cycle each.
//  req_valid while not in IDLE is ignored; requests are not queued.
//  Mem_WR, IR_Load and MDR_Load are mutually exclusive and never high outside WRITE/CAPT.
// TESTING
//  1. MEM_LATENCY=2; fetch at T.
//     -> IorD_Sel=000 over T+1..T+3; IR_Load=1 and done=1 at T+3 only; req_ready=0 over T+1..T+3.
//  2. Load word, src=00, addr_lo=00.
//     -> IorD_Sel=001 from T+1; MDR_Load=1 at T+3; err=00.
//  3. Store word, src=10, store_data=32'hCAFEBABE.
//     -> at T+1: IorD_Sel=011, Mem_WR=1, mem_wdata=CAFEBABE, done=1.
//  4. Store byte, addr_lo=10, store_data=32'h000000AB, mem_rdata=32'h11223344.
//     -> Mem_WR=1 at T+3 with mem_wdata=32'h11AB3344.
//  5. Load half with addr_lo=01 -> done=1 with err=01 at T+1; no Mem_WR, no MDR_Load.
//     req_src=11 on a store -> done=1 with err=10 at T+1.
//  6. Store half accepted, reset asserted at T+2 (in WAIT).
//     -> outputs drop to reset values immediately; no Mem_WR ever; next fetch completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Memory transaction sequencer for the multicycle CPU: address-source select,
// read-latency wait, IR/MDR capture strobes and read-modify-write sub-word stores.
module mem_access_sequencer #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_src,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  IorD_Sel,
    output logic        Mem_WR,
    output logic [31:0] mem_wdata,
    output logic        IR_Load,
    output logic        MDR_Load,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0] KIND_FETCH = 2'b00;
    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [1:0] KIND_EXC   = 2'b11;

    localparam logic [1:0] SIZE_WORD  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_BYTE  = 2'b10;
    localparam logic [1:0] SIZE_BAD   = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    // Counter preload: the wait state is left when the counter reaches zero.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_kind;
    logic [1:0]  r_size;
    logic [1:0]  r_addrLo;
    logic [31:0] r_storeData;
    logic [31:0] r_wdata;
    logic [2:0]  r_sel;
    logic [2:0]  r_cnt;
    logic [1:0]  r_err;

    logic        w_isMemOp;
    logic        w_isIllegal;
    logic        w_isMisaligned;
    logic [2:0]  w_selMap;
    logic [31:0] w_merge;

    assign w_isMemOp   = (req_kind == KIND_LOAD) || (req_kind == KIND_STORE);
    assign w_isIllegal = (req_size == SIZE_BAD)
                      || (w_isMemOp && (req_src == 2'b11))
                      || ((req_kind == KIND_FETCH) && (req_size != SIZE_WORD));
    assign w_isMisaligned = ((req_size == SIZE_WORD) && (addr_lo != 2'b00))
                         || ((req_size == SIZE_HALF) && addr_lo[0]);

    always_comb begin
        w_selMap = 3'b000;
        case (req_kind)
            KIND_FETCH: w_selMap = 3'b000;
            KIND_EXC:   w_selMap = 3'b100;
            default:    w_selMap = {1'b0, req_src} + 3'd1;
        endcase
    end

    // Sub-word store: splice the new lane into the word just read back.
    always_comb begin
        w_merge = mem_rdata;
        if (r_size == SIZE_BYTE) begin
            case (r_addrLo)
                2'd0:    w_merge[7:0]   = r_storeData[7:0];
                2'd1:    w_merge[15:8]  = r_storeData[7:0];
                2'd2:    w_merge[23:16] = r_storeData[7:0];
                default: w_merge[31:24] = r_storeData[7:0];
            endcase
        end else if (r_addrLo[1]) begin
            w_merge[31:16] = r_storeData[15:0];
        end else begin
            w_merge[15:0] = r_storeData[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_isIllegal || w_isMisaligned) begin
                        w_nextState = ERR;
                    end else if ((req_kind == KIND_STORE) && (req_size == SIZE_WORD)) begin
                        w_nextState = WRITE;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_nextState = (r_kind == KIND_STORE) ? WRITE : CAPT;
                end
            end
            CAPT, WRITE, ERR: w_nextState = IDLE;
            default:          w_nextState = IDLE;
        endcase
    end

    // Request latches, latency counter, select and write-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kind      <= KIND_FETCH;
            r_size      <= SIZE_WORD;
            r_addrLo    <= 2'b00;
            r_storeData <= 32'd0;
            r_wdata     <= 32'd0;
            r_sel       <= 3'b000;
            r_cnt       <= 3'd0;
            r_err       <= ERR_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_kind      <= req_kind;
                        r_size      <= req_size;
                        r_addrLo    <= addr_lo;
                        r_storeData <= store_data;
                        r_cnt       <= LAT_M1;
                        if (w_isIllegal) begin
                            r_err <= ERR_ILLEGAL;
                            r_sel <= 3'b000;
                        end else if (w_isMisaligned) begin
                            r_err <= ERR_ALIGN;
                            r_sel <= 3'b000;
                        end else begin
                            r_err <= ERR_OK;
                            r_sel <= w_selMap;
                        end
                        if ((req_kind == KIND_STORE) && (req_size == SIZE_WORD)) begin
                            r_wdata <= store_data;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else if (r_kind == KIND_STORE) begin
                        r_wdata <= w_merge;
                    end
                end
                default: r_sel <= 3'b000;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign IorD_Sel  = r_sel;
    assign Mem_WR    = (r_state == WRITE);
    assign mem_wdata = r_wdata;
    assign IR_Load   = (r_state == CAPT) && (r_kind == KIND_FETCH);
    assign MDR_Load  = (r_state == CAPT) && (r_kind != KIND_FETCH);
    assign done      = (r_state == CAPT) || (r_state == WRITE) || (r_state == ERR);
    assign err       = (r_state == ERR) ? r_err : ERR_OK;

endmodule
